// File: rtl/sprite_drawer.sv
// Per-line sprite rasteriser: walks the secondary sprite array, fetches OAM then VRAM
// one edge apart, and paints 16-pixel rows into a registered line buffer.
module sprite_drawer #(
    parameter int unsigned VRAM_ADDR_SIZE    = 12,
    parameter int unsigned VRAM_DATA_SIZE    = 128,
    parameter int unsigned SECOND_ARRAY_SIZE = 32,
    parameter int unsigned OAM_ADDR_SIZE     = 8,
    parameter int unsigned OAM_DATA_SIZE     = 32,
    parameter int unsigned DISPLAY_WIDTH     = 600,
    parameter int unsigned LINE_NUMBER_WIDTH = $clog2(DISPLAY_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    output logic                         done,
    output logic [OAM_ADDR_SIZE-1:0]     oam_a,
    input  logic [OAM_DATA_SIZE-1:0]     oam_d,
    output logic [VRAM_ADDR_SIZE-1:0]    vram_a,
    input  logic [VRAM_DATA_SIZE-1:0]    vram_d,
    input  logic [OAM_ADDR_SIZE:0]       second_array [0:SECOND_ARRAY_SIZE-1],
    input  logic [LINE_NUMBER_WIDTH-1:0] line_number,
    output logic [7:0]                   line_buffer [0:DISPLAY_WIDTH-1]
);
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned SA_W     = $clog2(SECOND_ARRAY_SIZE);
    localparam int unsigned SPRITE_W = 16;
    localparam int unsigned X_W      = 10;
    localparam int unsigned TILE_W   = 8;
    localparam int unsigned ROW_W    = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic              done_next;
    logic              s1_valid, s1_valid_next;
    logic [X_W-1:0]    s1_x;
    logic [TILE_W-1:0] s1_tile;
    logic [ROW_W-1:0]  s1_row;

    logic              load, clear, draw, fetch_ok;
    logic [SA_W-1:0]   sel;
    logic [LINE_NUMBER_WIDTH-1:0] row_diff;
    logic [X_W:0]      draw_pos [SPRITE_W];
    logic [7:0]        draw_px  [SPRITE_W];
    logic              draw_en  [SPRITE_W];
    logic              unused_oam_bits;

    assign unused_oam_bits = ^oam_d[OAM_DATA_SIZE-1:28];

    // Entry select: pinned to 0 in idle, saturated once the array is exhausted
    always_comb begin
        if (state == ST_IDLE)
            sel = '0;
        else if (idx >= IDX_W'(SECOND_ARRAY_SIZE))
            sel = SA_W'(SECOND_ARRAY_SIZE - 1);
        else
            sel = idx[SA_W-1:0];
    end

    assign oam_a    = second_array[sel][OAM_ADDR_SIZE:1];
    assign fetch_ok = (idx < IDX_W'(SECOND_ARRAY_SIZE)) && second_array[sel][0];
    assign row_diff = line_number - oam_d[27:18];
    assign vram_a   = VRAM_ADDR_SIZE'({s1_tile, s1_row});

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        done_next     = done;
        s1_valid_next = s1_valid;
        load          = 1'b0;
        clear         = 1'b0;
        draw          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    clear = 1'b1;
                    if (fetch_ok) begin
                        load       = 1'b1;
                        state_next = ST_RUN;
                    end else begin
                        s1_valid_next = 1'b0;
                        done_next     = 1'b1;
                        state_next    = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    s1_valid_next = 1'b0;
                    done_next     = 1'b0;
                    idx_next      = '0;
                    state_next    = ST_IDLE;
                end else begin
                    draw = s1_valid;
                    if (fetch_ok) begin
                        load = 1'b1;
                    end else begin
                        s1_valid_next = 1'b0;
                        done_next     = 1'b1;
                        state_next    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    done_next  = 1'b0;
                    idx_next   = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (load) begin
            s1_valid_next = 1'b1;
            idx_next      = idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            done     <= 1'b0;
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_tile  <= '0;
            s1_row   <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            done     <= done_next;
            s1_valid <= s1_valid_next;
            if (load) begin
                s1_x    <= oam_d[17:8];
                s1_tile <= oam_d[7:0];
                s1_row  <= row_diff[ROW_W-1:0];
            end
        end
    end

    // Per-pixel write enables: opaque and on-screen only
    always_comb begin
        for (int k = 0; k < SPRITE_W; k++) begin
            draw_pos[k] = {1'b0, s1_x} + (X_W+1)'(k);
            draw_px[k]  = vram_d[8*k +: 8];
            draw_en[k]  = draw && (draw_px[k] != 8'd0) &&
                          (draw_pos[k] < (X_W+1)'(DISPLAY_WIDTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int p = 0; p < DISPLAY_WIDTH; p++)
                line_buffer[p] <= 8'd0;
        end else begin
            for (int k = 0; k < SPRITE_W; k++)
                if (draw_en[k])
                    line_buffer[draw_pos[k][X_W-1:0]] <= draw_px[k];
        end
    end

endmodule

// File: tb/tb_sprite_drawer.sv
// Randomised and directed checks of sprite_drawer against a per-line painter's-algorithm model.
module tb_sprite_drawer;
    localparam int unsigned NSA = 32;
    localparam int unsigned DW  = 600;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         done;
    logic [7:0]   oam_a;
    logic [31:0]  oam_d;
    logic [11:0]  vram_a;
    logic [127:0] vram_d;
    logic [8:0]   second_array [0:NSA-1];
    logic [9:0]   line_number;
    logic [7:0]   line_buffer [0:DW-1];

    logic [31:0]  oam_mem  [0:255];
    logic [127:0] vram_mem [0:4095];
    logic [7:0]   exp_line [0:DW-1];

    int n_cmp = 0;
    int n_bad = 0;

    sprite_drawer dut (
        .clk(clk), .rst(rst), .enable(enable), .done(done),
        .oam_a(oam_a), .oam_d(oam_d), .vram_a(vram_a), .vram_d(vram_d),
        .second_array(second_array), .line_number(line_number),
        .line_buffer(line_buffer)
    );

    assign oam_d  = oam_mem[oam_a];
    assign vram_d = vram_mem[vram_a];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_entries();
        for (int i = 0; i < NSA; i++)
            second_array[i] = {8'($urandom), 1'b0};
    endtask

    task automatic set_entry(input int i, input int addr, input int x, input int y, input int tile);
        second_array[i] = {8'(addr), 1'b1};
        oam_mem[addr]   = {4'h0, 10'(y), 10'(x), 8'(tile)};
    endtask

    // Painter's algorithm over the first n entries: later entries win, zeros transparent
    task automatic build_model(input int n);
        logic [31:0]  w;
        logic [127:0] data;
        logic [7:0]   b;
        int x, y, t, row;
        for (int p = 0; p < DW; p++) exp_line[p] = 8'd0;
        for (int e = 0; e < n; e++) begin
            w    = oam_mem[second_array[e][8:1]];
            y    = int'(w[27:18]);
            x    = int'(w[17:8]);
            t    = int'(w[7:0]);
            row  = (int'(line_number) - y) & 15;
            data = vram_mem[t * 16 + row];
            for (int k = 0; k < 16; k++) begin
                b = data[8*k +: 8];
                if (b != 8'd0 && x + k < DW) exp_line[x + k] = b;
            end
        end
    endtask

    task automatic check_line(input string tag);
        for (int p = 0; p < DW; p++)
            chk(tag, 64'(line_buffer[p]), 64'(exp_line[p]));
    endtask

    // Full line with n active entries: timing of done, content, hold, release
    task automatic run_line(input int n, input string tag);
        int edges = 0;
        enable = 1'b1;
        while (!done && edges < 40) begin
            step();
            edges++;
        end
        chk({tag, "_edges"}, 64'(edges), 64'(n + 1));
        build_model(n);
        check_line({tag, "_pix"});
        step();
        chk({tag, "_hold"}, 64'(done), 64'd1);
        enable = 1'b0;
        step();
        chk({tag, "_release"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int ybase;
        rst = 1'b1;
        enable = 1'b0;
        line_number = 10'd0;
        for (int a = 0; a < 256; a++) oam_mem[a] = $urandom;
        for (int a = 0; a < 4096; a++)
            for (int k = 0; k < 16; k++)
                vram_mem[a][8*k +: 8] = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'd0;
        clear_entries();
        step();
        step();
        rst = 1'b0;
        chk("reset_done", 64'(done), 64'd0);
        build_model(0);
        check_line("reset_pix");
        chk("reset_oam_a", 64'(oam_a), 64'(second_array[0][8:1]));

        // 16 entries at consecutive OAM addresses, spaced 20 pixels apart
        clear_entries();
        line_number = 10'd0;
        for (int i = 0; i < 16; i++) set_entry(i, i, 20 * i, 0, i);
        enable = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            step();
            chk("seq_oam_a", 64'(oam_a), 64'(second_array[j][8:1]));
            chk("seq_vram_tile", 64'(vram_a[11:4]), 64'(j - 1));
            chk("seq_done_low", 64'(done), 64'd0);
        end
        step();
        chk("seq_done", 64'(done), 64'd1);
        build_model(16);
        check_line("seq_pix");
        enable = 1'b0;
        step();
        chk("seq_release", 64'(done), 64'd0);

        // No active entries
        clear_entries();
        run_line(0, "empty");

        // Right-edge clipping
        clear_entries();
        line_number = 10'd40;
        set_entry(0, 7, 590, 40, 3);
        vram_mem[3 * 16] = {16{8'hFF}};
        run_line(1, "clip");

        // Overlap with transparency
        clear_entries();
        line_number = 10'd9;
        set_entry(0, 50, 100, 9, 5);
        set_entry(1, 51, 100, 9, 6);
        vram_mem[5 * 16] = {16{8'h11}};
        vram_mem[6 * 16] = {8{8'h22, 8'h00}};
        enable = 1'b1;
        for (int e = 0; e < 3; e++) step();
        chk("ovl_done", 64'(done), 64'd1);
        chk("ovl_p100", 64'(line_buffer[100]), 64'h11);
        chk("ovl_p101", 64'(line_buffer[101]), 64'h22);
        chk("ovl_p115", 64'(line_buffer[115]), 64'h22);
        build_model(2);
        check_line("ovl_pix");
        enable = 1'b0;
        step();

        // Row select and mid-run abort
        clear_entries();
        line_number = 10'd12;
        set_entry(0, 10, 30, 5, 1);
        set_entry(1, 20, 60, 5, 2);
        set_entry(2, 30, 90, 5, 4);
        enable = 1'b1;
        step();
        chk("row_nibble", 64'(vram_a[3:0]), 64'd7);
        step();
        chk("abort_oam_a_run", 64'(oam_a), 64'(second_array[2][8:1]));
        enable = 1'b0;
        step();
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_oam_a", 64'(oam_a), 64'(second_array[0][8:1]));
        step();
        chk("abort_done2", 64'(done), 64'd0);

        // Randomised lines, including a completely full array
        for (int it = 0; it < 8; it++) begin
            clear_entries();
            n = (it == 0) ? NSA : $urandom_range(0, NSA);
            line_number = 10'($urandom_range(0, DW - 1));
            for (int e = 0; e < n; e++) begin
                ybase = int'(line_number) - $urandom_range(0, 15);
                set_entry(e, $urandom_range(0, 255),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(580, DW - 1)
                                                      : $urandom_range(0, DW - 1),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : (ybase & 1023),
                          $urandom_range(0, 255));
            end
            run_line(n, "rand");
        end

        // Reset while in DONE with enable still high
        clear_entries();
        line_number = 10'd3;
        set_entry(0, 90, 10, 3, 8);
        vram_mem[8 * 16 + 0] = {16{8'h5A}};
        enable = 1'b1;
        step();
        step();
        chk("rstdone_pre", 64'(done), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        enable = 1'b0;
        chk("rstdone_done", 64'(done), 64'd0);
        chk("rstdone_oam_a", 64'(oam_a), 64'(second_array[0][8:1]));
        build_model(0);
        check_line("rstdone_pix");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sprite_drawer.md
SPRITE_DRAWER -- requirements
Module: sprite_drawer

Interface
REQ-001 Parameter VRAM_ADDR_SIZE, 12, VRAM word address width.
REQ-002 Parameter VRAM_DATA_SIZE, 128, VRAM word width (one 16-pixel sprite row).
REQ-003 Parameter SECOND_ARRAY_SIZE, 32, entries in the secondary sprite array.
REQ-004 Parameter OAM_ADDR_SIZE, 8, OAM address width; OAM_DATA_SIZE, 32, OAM word width.
REQ-005 Parameter DISPLAY_WIDTH, 600, pixels per line; LINE_NUMBER_WIDTH, $clog2(DISPLAY_WIDTH)=10.
REQ-006 Single clock domain; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 enable  in  1  level request to draw the current line; deassertion returns the block to idle.
REQ-010 done  out  1  registered; high when the line is fully drawn, held while enable stays high.
REQ-011 oam_a  out  OAM_ADDR_SIZE  combinational OAM read address.
REQ-012 oam_d  in  OAM_DATA_SIZE  OAM word for oam_a, sampled on the same clk edge (zero-latency read).
REQ-013 vram_a  out  VRAM_ADDR_SIZE  combinational VRAM address = {tile[7:0], row[3:0]}.
REQ-014 vram_d  in  VRAM_DATA_SIZE  VRAM word for vram_a, sampled on the same edge.
REQ-015 second_array  in  SECOND_ARRAY_SIZE x (OAM_ADDR_SIZE+1)  per entry: [8:1] OAM address, [0] active flag; active entries are packed from index 0.
REQ-016 line_number  in  LINE_NUMBER_WIDTH  current display line.
REQ-017 line_buffer  out  DISPLAY_WIDTH x 8  registered pixel line; pixel p = line_buffer[p].

Function
REQ-018 OAM word format: [31:28] unused, [27:18] y, [17:8] x, [7:0] tile index.
REQ-019 Pixel k (0..15) of a sprite row = vram_d[8k+7:8k], drawn at line_buffer[x+k].
REQ-020 States: IDLE, RUN, DONE; a 6-bit entry index idx; a stage-1 register {valid, x, tile, row}.
REQ-021 oam_a = second_array[idx][8:1] (idx 0 in IDLE; idx saturated to SECOND_ARRAY_SIZE-1 when ≥ SECOND_ARRAY_SIZE).
REQ-022 Fetch: on an edge in IDLE with enable=1, or in RUN, if idx<SECOND_ARRAY_SIZE and second_array[idx][0]=1, latch stage-1 valid=1, x=oam_d[17:8], tile=oam_d[7:0], row=(line_number-oam_d[27:18])[3:0], and increment idx.
REQ-023 No further fetch once an inactive entry or idx=SECOND_ARRAY_SIZE is reached; stage-1 valid←0 on that edge.
REQ-024 vram_a = {stage-1 tile, stage-1 row}, so VRAM data for entry k is consumed one edge after its OAM fetch.
REQ-025 Draw: on each edge where stage-1 valid=1, write pixels k=0..15 with value ≠0 to line_buffer[x+k]; zero pixels are transparent (not written).
REQ-026 Pixels with x+k ≥ DISPLAY_WIDTH are discarded (no wrap).
REQ-027 Overlap: a later entry overwrites earlier entries' non-transparent pixels.
REQ-028 On the IDLE→RUN edge line_buffer is cleared to 0 (clear precedes any write of that line).
REQ-029 done←1 and state←DONE on the edge where no fetch occurs (REQ-023); that edge also performs the final draw; N active entries → done high after N+1 edges from the start edge.
REQ-030 N=0: start edge clears buffer, sets done=1, state DONE.
REQ-031 DONE: hold done=1 and line_buffer; enable=0 → IDLE, done←0, idx←0.
REQ-032 enable=0 during RUN: abort to IDLE, done=0, stage-1 invalid, line_buffer keeps partial content.

Reset
REQ-033 rst=1 at an edge: state IDLE, idx=0, stage-1 valid=0, done=0, line_buffer all 0; rst overrides enable.

Verification
REQ-034 16 active entries i=0..15 at OAM addr i, x=20i, y=0, tile=i, line_number=0, random rows: edge k fetch shows oam_a=k; next cycle vram_a[11:4]=k; done=1 by edge 17; line_buffer[20i+:16]==row_i for nonzero bytes.
REQ-035 All entries inactive, enable=1 -> done=1 after one edge, line_buffer all 0, vram unused.
REQ-036 Sprite x=590, row all 0xFF -> pixels 590..599=0xFF, nothing else written, no wrap to 0..5.
REQ-037 Two entries same x=100, first row 0x11 bytes, second row with alternate bytes 0x00/0x22 -> pixels alternate 0x11/0x22 (transparency, later priority).
REQ-038 y=5, line_number=12 -> vram_a low nibble=7; enable dropped mid-RUN -> done=0, state IDLE next edge.
REQ-039 rst pulsed in DONE -> done=0, line_buffer cleared, oam_a=second_array[0][8:1].
